// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: valid/ready configuration port for tick_scheduler.
// The master selects a channel and either starts/reprograms or stops it.
interface tick_scheduler_if #(
   parameter int NCH  = 4,
   parameter int DIVW = 32
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic            cfg_valid;
   logic            cfg_ready;
   logic [CHW-1:0]  cfg_ch;
   logic            cfg_run;
   logic [DIVW-1:0] cfg_div;

   modport master (
      output cfg_valid, cfg_ch, cfg_run, cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_run, cfg_div,
      output cfg_ready
   );
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: NCH independent clock-divider channels, glitch-free reload.
// Define TICK_SCHED_SYNC_EN to add the i_sync realignment input.
module tick_scheduler #(
   parameter int NCH         = 4,
   parameter int DIVW        = 32,
   parameter int DEFAULT_DIV = 25
) (
   input  logic           i_CLKin,
   input  logic           i_clr,
`ifdef TICK_SCHED_SYNC_EN
   input  logic           i_sync,
`endif
   tick_scheduler_if.slave s_cfg,
   output logic [NCH-1:0] o_clk_out,
   output logic [NCH-1:0] o_tick,
   output logic           o_busy
);
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_RELOAD
   } state_t;

   localparam logic [DIVW-1:0] LP_DEF = DIVW'(DEFAULT_DIV);
   localparam logic [DIVW-1:0] LP_ONE = DIVW'(1);

   state_t          r_state  [NCH];
   state_t          w_state_n[NCH];
   logic [DIVW-1:0] r_cnt    [NCH];
   logic [DIVW-1:0] w_cnt_n  [NCH];
   logic [DIVW-1:0] r_div    [NCH];
   logic [DIVW-1:0] w_div_n  [NCH];
   logic [DIVW-1:0] r_pend   [NCH];
   logic [DIVW-1:0] w_pend_n [NCH];
   logic [NCH-1:0]  r_clk;
   logic [NCH-1:0]  w_clk_n;
   logic [NCH-1:0]  r_tick;
   logic [NCH-1:0]  w_tick_n;
   logic [NCH-1:0]  w_term;
   logic [NCH-1:0]  w_sel;
   logic            r_busy;
   logic            w_busy_n;
   logic            w_ch_ok;
   logic            w_acc;
   logic            w_sync;

`ifdef TICK_SCHED_SYNC_EN
   assign w_sync = i_sync;
`else
   assign w_sync = 1'b0;
`endif

   // Out-of-range channels are always ready so they are consumed.
   assign w_ch_ok = 32'(s_cfg.cfg_ch) < NCH;
   assign s_cfg.cfg_ready = !s_cfg.cfg_run || !w_ch_ok ||
                            (r_state[s_cfg.cfg_ch] != ST_RELOAD);
   assign w_acc = s_cfg.cfg_valid && s_cfg.cfg_ready;

   always_comb begin
      w_sel  = '0;
      w_term = '0;
      for (int i = 0; i < NCH; i++) begin
         w_sel[i]  = w_acc && (32'(s_cfg.cfg_ch) == i);
         w_term[i] = (r_cnt[i] == r_div[i]);
      end
   end

   always_comb begin
      w_busy_n = 1'b0;
      w_clk_n  = r_clk;
      w_tick_n = '0;
      for (int i = 0; i < NCH; i++) begin
         w_state_n[i] = r_state[i];
         w_cnt_n[i]   = r_cnt[i];
         w_div_n[i]   = r_div[i];
         w_pend_n[i]  = r_pend[i];
         unique case (r_state[i])
            ST_IDLE: begin
               w_cnt_n[i] = '0;
               w_clk_n[i] = 1'b0;
               if (w_sel[i] && s_cfg.cfg_run) begin
                  w_div_n[i]   = s_cfg.cfg_div;
                  w_state_n[i] = ST_RUN;
               end
            end
            ST_RUN, ST_RELOAD: begin
               if (w_term[i]) begin
                  w_cnt_n[i]  = '0;
                  w_clk_n[i]  = ~r_clk[i];
                  w_tick_n[i] = 1'b1;
                  if (r_state[i] == ST_RELOAD) begin
                     w_div_n[i]   = r_pend[i];
                     w_state_n[i] = ST_RUN;
                  end
               end else begin
                  w_cnt_n[i] = r_cnt[i] + LP_ONE;
               end
               // A same-cycle request overrides sync for its channel.
               if (w_sel[i]) begin
                  if (s_cfg.cfg_run) begin
                     w_pend_n[i]  = s_cfg.cfg_div;
                     w_state_n[i] = ST_RELOAD;
                  end else begin
                     w_cnt_n[i]   = '0;
                     w_clk_n[i]   = 1'b0;
                     w_tick_n[i]  = 1'b0;
                     w_state_n[i] = ST_IDLE;
                  end
               end else if (w_sync) begin
                  w_cnt_n[i]  = '0;
                  w_clk_n[i]  = 1'b0;
                  w_tick_n[i] = 1'b0;
                  if (r_state[i] == ST_RELOAD) begin
                     w_div_n[i]   = r_pend[i];
                     w_state_n[i] = ST_RUN;
                  end
               end
            end
            default: w_state_n[i] = ST_IDLE;
         endcase
         if (w_state_n[i] != ST_IDLE) w_busy_n = 1'b1;
      end
   end

   always_ff @(posedge i_CLKin or posedge i_clr) begin
      if (i_clr) begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
            r_div[i]   <= LP_DEF;
            r_pend[i]  <= LP_DEF;
         end
         r_clk  <= '0;
         r_tick <= '0;
         r_busy <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= w_state_n[i];
            r_cnt[i]   <= w_cnt_n[i];
            r_div[i]   <= w_div_n[i];
            r_pend[i]  <= w_pend_n[i];
         end
         r_clk  <= w_clk_n;
         r_tick <= w_tick_n;
         r_busy <= w_busy_n;
      end
   end

   assign o_clk_out = r_clk;
   assign o_tick    = r_tick;
   assign o_busy    = r_busy;
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed stimulus; expected ticks queued per channel,
// a monitor pops and checks each tick edge and clk_out level.
module tb_tick_scheduler;
   localparam int NCH = 4;

   typedef struct {
      int   e;
      logic lvl;
   } exp_t;

   logic           clk;
   logic           clr;
`ifdef TICK_SCHED_SYNC_EN
   logic           sync;
`endif
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;
   logic           busy;
   int             cyc    = 0;
   int             n_chk  = 0;
   int             n_fail = 0;
   exp_t           expq [NCH][$];

   tick_scheduler_if #(.NCH(NCH), .DIVW(32)) cif ();

   tick_scheduler #(
      .NCH(NCH), .DIVW(32), .DEFAULT_DIV(25)
   ) dut (
      .i_CLKin  (clk),
      .i_clr    (clr),
`ifdef TICK_SCHED_SYNC_EN
      .i_sync   (sync),
`endif
      .s_cfg    (cif),
      .o_clk_out(clk_out),
      .o_tick   (tick),
      .o_busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (edge %0d)",
                  nm, act, req, cyc);
      end
   endtask

   task automatic push_ticks(input int ch, input int first, input int step,
                             input int cnt, input logic lvl0);
      logic l;
      l = lvl0;
      for (int m = 0; m < cnt; m++) begin
         expq[ch].push_back('{first + step * m, l});
         l = ~l;
      end
   endtask

   task automatic wait_until(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic cfg(input int ch, input logic run, input logic [31:0] dv,
                      output int k);
      int n;
      n = 0;
      cif.cfg_valid = 1'b1;
      cif.cfg_ch    = 2'(ch);
      cif.cfg_run   = run;
      cif.cfg_div   = dv;
      #1;
      while (!cif.cfg_ready && n < 64) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("cfg_ready_wait", 64'(cif.cfg_ready), 64'd1);
      k = cyc + 1;
      @(negedge clk);
      cif.cfg_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!clr) begin
         for (int c = 0; c < NCH; c++) begin
            if (expq[c].size() > 0 && expq[c][0].e < cyc) begin
               n_chk++;
               n_fail++;
               $display("FAIL missing_tick ch%0d: got none required edge %0d",
                        c, expq[c][0].e);
               void'(expq[c].pop_front());
            end
            if (tick[c]) begin
               n_chk++;
               if (expq[c].size() == 0) begin
                  n_fail++;
                  $display("FAIL extra_tick ch%0d: got tick at %0d required none",
                           c, cyc);
               end else begin
                  exp_t x;
                  x = expq[c].pop_front();
                  if (x.e != cyc || x.lvl !== clk_out[c]) begin
                     n_fail++;
                     $display("FAIL tick ch%0d: got edge %0d lvl %0b required edge %0d lvl %0b",
                              c, cyc, clk_out[c], x.e, x.lvl);
                  end
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k0, k1, k2, k3, kb, kx;
      int ka [NCH];
`ifdef TICK_SCHED_SYNC_EN
      int ks, kt;
      sync = 1'b0;
`endif
      clr           = 1'b1;
      cif.cfg_valid = 1'b0;
      cif.cfg_ch    = '0;
      cif.cfg_run   = 1'b1;
      cif.cfg_div   = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_clk_out", 64'(clk_out), 64'd0);
      chk("rst_tick", 64'(tick), 64'd0);
      clr = 1'b0;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_ready", 64'(cif.cfg_ready), 64'd1);

      // ch0 default divisor: half period 26
      cfg(0, 1'b1, 32'd25, k0);
      chk("busy_after_start", 64'(busy), 64'd1);
      push_ticks(0, k0 + 26, 26, 3, 1'b1);

      // ch1 div=3, then reload to 1 on a terminal cycle
      cfg(1, 1'b1, 32'd3, k1);
      push_ticks(1, k1 + 4, 4, 2, 1'b1);
      wait_until(k1 + 7);
      cfg(1, 1'b1, 32'd1, kx);
      push_ticks(1, k1 + 12, 2, 3, 1'b1);
      wait_until(k1 + 16);
      cfg(1, 1'b0, 32'd0, kx);
      chk("ch1_stop_clk", 64'(clk_out[1]), 64'd0);
      chk("ch23_quiet", 64'(clk_out[3:2]), 64'd0);

      // ch2 div=9, reload to 1 mid-count
      cfg(2, 1'b1, 32'd9, k2);
      push_ticks(2, k2 + 10, 10, 1, 1'b1);
      wait_until(k2 + 4);
      cfg(2, 1'b1, 32'd1, kx);
      wait_until(k2 + 7);
      cif.cfg_ch  = 2'd2;
      cif.cfg_run = 1'b1;
      #1 chk("ready_in_reload", 64'(cif.cfg_ready), 64'd0);
      cif.cfg_run = 1'b0;
      #1 chk("ready_stop_reload", 64'(cif.cfg_ready), 64'd1);
      cif.cfg_ch  = 2'd0;
      cif.cfg_run = 1'b1;
      #1 chk("ready_other_ch", 64'(cif.cfg_ready), 64'd1);
      wait_until(k2 + 9);
      cif.cfg_ch = 2'd2;
      #1 chk("ready_before_term", 64'(cif.cfg_ready), 64'd0);
      wait_until(k2 + 10);
      #1 chk("ready_after_term", 64'(cif.cfg_ready), 64'd1);
      push_ticks(2, k2 + 12, 2, 3, 1'b0);
      wait_until(k2 + 16);
      cfg(2, 1'b0, 32'd0, kx);
      chk("busy_ch0_only", 64'(busy), 64'd1);

      // ch0 half-period boundary, then stop while high
      wait_until(k0 + 51);
      chk("ch0_high_end", 64'(clk_out[0]), 64'd1);
      wait_until(k0 + 52);
      chk("ch0_low_start", 64'(clk_out[0]), 64'd0);
      wait_until(k0 + 79);
      cfg(0, 1'b0, 32'd0, kx);
      chk("ch0_stop_clk", 64'(clk_out[0]), 64'd0);

      // ch3 div=0, stop on a terminal cycle
      cfg(3, 1'b1, 32'd0, k3);
      push_ticks(3, k3 + 1, 1, 3, 1'b1);
      wait_until(k3 + 3);
      cfg(3, 1'b0, 32'd0, kx);
      chk("ch3_stop_clk", 64'(clk_out[3]), 64'd0);
      chk("ch3_stop_tick", 64'(tick[3]), 64'd0);
      chk("busy_drop", 64'(busy), 64'd0);

      // async clear with all channels running
      for (int c = 0; c < NCH; c++) begin
         cfg(c, 1'b1, 32'd7, ka[c]);
         push_ticks(c, ka[c] + 8, 8, 1, 1'b1);
      end
      wait_until(ka[3] + 8);
      #1 chk("pre_clr_clk", 64'(clk_out), 64'hF);
      #1 clr = 1'b1;
      #1;
      chk("clr_clk_out", 64'(clk_out), 64'd0);
      chk("clr_tick", 64'(tick), 64'd0);
      chk("clr_busy", 64'(busy), 64'd0);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      cfg(0, 1'b1, 32'd3, kb);
      chk("busy_after_clr", 64'(busy), 64'd1);
      push_ticks(0, kb + 4, 4, 2, 1'b1);
      wait_until(kb + 8);
      cfg(0, 1'b0, 32'd0, kx);
      chk("busy_final", 64'(busy), 64'd0);

`ifdef TICK_SCHED_SYNC_EN
      cfg(0, 1'b1, 32'd5, ks);
      push_ticks(0, ks + 6, 6, 2, 1'b1);
      cfg(1, 1'b1, 32'd7, kt);
      push_ticks(1, kt + 8, 8, 1, 1'b1);
      wait_until(ks + 13);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      chk("sync_clk", 64'(clk_out[1:0]), 64'd0);
      push_ticks(0, ks + 20, 6, 1, 1'b1);
      push_ticks(1, ks + 22, 8, 1, 1'b1);
      wait_until(ks + 22);
      cfg(0, 1'b0, 32'd0, kx);
      cfg(1, 1'b0, 32'd0, kx);
`endif

      repeat (40) @(negedge clk);
      for (int c = 0; c < NCH; c++)
         chk("queue_drained", 64'(expq[c].size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel, run-time programmable clock-divider controller. It owns NCH divider channels and sequences each one through idle, run and glitch-free divisor reload. Channels are configured through a single valid/ready configuration port. It sits between the control FSMs and every block that needs a slowed clock (square wave) or a one-cycle enable strobe (tick).

## Interface
- NCH, 4, number of divider channels; 1..16.
- DIVW, 32, divisor and counter width per channel.
- DEFAULT_DIV, 25, divisor loaded into every channel at reset.
- CLKin  input  1  system clock; all logic on rising edge.
- clr  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  configuration request valid.
- cfg_ready  output  1  configuration request can be accepted this cycle.
- cfg_ch  input  clog2(NCH), min 1  target channel index.
- cfg_run  input  1  1 = start or re-program channel; 0 = stop channel.
- cfg_div  input  DIVW  new divisor; ignored when cfg_run=0.
- clk_out  output  NCH  per-channel divided square wave, registered.
- tick  output  NCH  per-channel one-cycle strobe, registered.
- busy  output  1  OR of all channels not in IDLE, registered.

## Operation
- Each channel has a state register, a cnt register (DIVW), a div register (DIVW) and a pend_div register (DIVW). States are IDLE, RUN and RELOAD.
- Divisor semantics: the channel counts cnt 0..div. When cnt==div, cnt returns to 0, clk_out toggles and tick pulses. Otherwise cnt increments.
  - Half period = div+1 cycles; full period = 2*(div+1) cycles.
  - div=0 toggles clk_out every cycle.
- Counter arithmetic is unsigned modulo 2^DIVW. Wrap never occurs because cnt≤div.
- A request is accepted when cfg_valid && cfg_ready.
- cfg_ready = !cfg_run || state[cfg_ch]!=RELOAD. It is combinational on cfg_ch and cfg_run and independent of cfg_valid.
- An accepted request with cfg_ch ≥ NCH is consumed and ignored.
- IDLE + accept(run=1): div←cfg_div, cnt←0, clk_out←0 → RUN.
- RUN + accept(run=1): pend_div←cfg_div → RELOAD. The counter keeps running on the old div.
- RELOAD at terminal count (cnt==div): div←pend_div, cnt←0, clk_out toggles, tick pulses → RUN.
- RUN or RELOAD + accept(run=0): cnt←0, clk_out←0, tick←0, pending reload discarded → IDLE.
- IDLE + accept(run=0): no effect.
- In IDLE: cnt holds 0, clk_out=0, tick=0, and div retains its last value.
- Channels are fully independent. Only one channel can be configured per cycle.

## Timing
- Reset values: state=IDLE, cnt=0, div=pend_div=DEFAULT_DIV, clk_out=0, tick=0, busy=0. Reset is asynchronous on assertion; deassertion is expected synchronous to CLKin.
- Start accepted at edge k:
  - State is RUN and cnt=0 after edge k.
  - The first clk_out rise and tick occur after edge k+div+1.
  - Toggles then repeat every div+1 edges.
- tick is high for exactly the cycle that follows each toggle edge.
- busy reflects state one edge after acceptance.
- Reload accepted mid-count: the current half period completes on the old div. The new div governs the half period that starts at that terminal edge. clk_out never glitches and no half period is shortened.
- Reload accepted in the same cycle that cnt==div: the terminal count takes the old path (toggle, cnt←0, still RUN). The pending reload applies at the next terminal count.
- Stop accepted in the same cycle as a terminal count: stop wins. clk_out←0 and tick stays 0.
- clr mid-operation: all channels go to IDLE immediately and outputs go to their reset values.

## Configuration
- TICK_SCHED_SYNC_EN defined: adds input port sync (1 bit), placed after clr. While sync=1, every channel in RUN or RELOAD is forced to cnt←0 and clk_out←0, and tick is suppressed. A pending reload is applied (div←pend_div, RELOAD → RUN). A configuration request accepted in the same cycle has priority over sync for its target channel.
- TICK_SCHED_SYNC_EN undefined: there is no sync port and channels are never realigned except by stop/start.

## Test plan
- Reset → busy=0, all clk_out=0, all tick=0. A start on ch0 with cfg_div=DEFAULT_DIV (25) → clk_out[0] period 52 cycles, tick[0] every 26 cycles.
- Start ch1 with div=3 at edge k → first clk_out[1] rise after edge k+4, period 8 cycles. The other channels stay 0.
- ch2 running div=9: at cnt=4, reload div=1 → cfg_ready for ch2 low (run=1) until the terminal edge. The half period completes at 10 cycles, then half periods are 2 cycles, with no glitch.
- ch3 running div=0 (toggle every cycle): stop issued on a terminal cycle → clk_out[3]=0 and tick[3]=0 the next cycle. State is IDLE and busy drops if no other channel is active.
- clr asserted asynchronously mid-count on all channels → outputs go to reset values without waiting for a clock edge. A fresh start after clr behaves as after power-up.
- With TICK_SCHED_SYNC_EN: ch0 div=5 and ch1 div=7 running out of phase, pulse sync → both channels have cnt=0 and clk_out=0. The next toggles occur at 6 and 8 cycles after sync deassertion.
